// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and produces one quotient
// bit per clock. Divide-by-zero and quotient overflow are detected up front and
// answered in a single cycle. All outputs come straight from flops.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_by_zero,
   output logic               overflow
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder, always < divisor
   logic [WIDTH-1:0] shift_q, shift_d;  // dividend low bits out, quotient bits in
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH:0]   trial_s;
   logic [WIDTH:0]   diff_s;
   logic             trial_ge_s;
   logic [WIDTH-1:0] step_rem_s;
   logic [WIDTH-1:0] step_shift_s;

   // One restoring step: bring down the next dividend bit and try to subtract.
   always_comb begin
      trial_s    = {rem_q, shift_q[WIDTH-1]};
      diff_s     = trial_s - {1'b0, dvs_q};
      trial_ge_s = (trial_s >= {1'b0, dvs_q});
      if (trial_ge_s) begin
         step_rem_s = diff_s[WIDTH-1:0];
      end else begin
         step_rem_s = trial_s[WIDTH-1:0];
      end
      step_shift_s = {shift_q[WIDTH-2:0], trial_ge_s};
   end

   // Next-state and next-output logic; everything holds unless a branch updates it.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      shift_d = shift_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dvs_d = divisor;
               if (divisor == {WIDTH{1'b0}}) begin
                  state_d = S_DONE;
                  dbz_d   = 1'b1;
                  ovf_d   = 1'b0;
                  quot_d  = {WIDTH{1'b1}};
                  rmd_d   = dividend[WIDTH-1:0];
               end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                  state_d = S_DONE;
                  dbz_d   = 1'b0;
                  ovf_d   = 1'b1;
                  quot_d  = {WIDTH{1'b1}};
                  rmd_d   = {WIDTH{1'b0}};
               end else begin
                  state_d = S_RUN;
                  rem_d   = dividend[2*WIDTH-1:WIDTH];
                  shift_d = dividend[WIDTH-1:0];
                  cnt_d   = {CNT_W{1'b0}};
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            rem_d   = step_rem_s;
            shift_d = step_shift_s;
            if (cnt_q == LAST_STEP) begin
               state_d = S_DONE;
               quot_d  = step_shift_s;
               rmd_d   = step_rem_s;
               dbz_d   = 1'b0;
               ovf_d   = 1'b0;
            end else begin
               state_d = S_RUN;
               cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; reset aborts any operation with no done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         rem_q   <= {WIDTH{1'b0}};
         shift_q <= {WIDTH{1'b0}};
         dvs_q   <= {WIDTH{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         quot_q  <= {WIDTH{1'b0}};
         rmd_q   <= {WIDTH{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         shift_q <= shift_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rmd_q   <= rmd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule
